multicycle_vector_controller: RTL
=================================

Name: multicycle_vector_controller

Overview:
- Multicycle successor to the single-cycle control decoder of the Filter-GPU control unit.
- Sequences each instruction through an FSM of FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Adds an internal NZCV flag register, conditional execution, and a parametrised vector-lane loop, so one datapath drives LANES pixel lanes per vector instruction.
- Sits between the instruction register and the shared datapath; it drives all datapath enables and muxes.

Parameters:
- LANES, 4, number of lanes iterated by a vector instruction (2..16).
- LANE_W, 2, width of LaneIdx; must satisfy 2**LANE_W >= LANES.
- ALUCTRL_W, 4, width of ALUControl.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- Cond  in  4  instruction condition field, Instr[31:28].
- Op  in  2  opcode class: 00 data-processing, 01 memory, 10 branch, 11 vector data-processing.
- Funct  in  6  Instr[25:20] = {I, cmd[3:0], S}; for memory, Funct[0] = L.
- Rd  in  4  destination register.
- ALUFlags  in  4  NZCV from the ALU, current cycle.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  data-memory write enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult.
- ALUSrcA  out  1  0 = RD1, 1 = PC.
- ALUSrcB  out  2  00 = RD2, 01 = Imm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult.
- ImmSrc  out  2  equals Op for Op 00/01/10; 00 for Op 11.
- RegSrc  out  2  {store: Op==01, branch: Op==10}.
- ALUControl  out  ALUCTRL_W  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR.
- LaneIdx  out  LANE_W  active lane during vector execution; 0 otherwise.
- Busy  out  1  high in every state except FETCH.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, VEXEC.
- Reset: state = FETCH, Flags = 0000, CondExReg = 0, LaneIdx = 0.
- While rst_n = 0, PCWrite, IRWrite, RegWrite and MemWrite are 0; all other outputs hold their FETCH values.
- FETCH: IRWrite = 1, PCWrite = 1, AdrSrc = 0, ALUSrcA = 1, ALUSrcB = 10, ALUControl = ADD, ResultSrc = 10. Next state is DECODE.
- DECODE:
  - Outputs ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10.
  - Evaluates CondEx from Cond and the registered Flags; latches CondExReg.
  - Cond encoding: 0000 EQ, 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 0110 VS, 0111 VC, 1000 HI, 1001 LS, 1010 GE, 1011 LT, 1100 GT, 1101 LE, 1110 AL; 1111 → CondEx = 0.
  - Next state: Op 01 → MEMADR; Op 10 → BRANCH; Op 00 with Funct[5] = 1 → EXECI, else EXECR; Op 11 → VEXEC with LaneIdx = 0.
- MEMADR: ALUSrcB = 01, ADD. Next state: Funct[0] = 1 → MEMRD, else MEMWR.
- MEMRD: AdrSrc = 1. Next state is MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = CondExReg. Next state is FETCH.
- MEMWR: AdrSrc = 1, MemWrite = CondExReg. Next state is FETCH.
- EXECR / EXECI: ALUSrcA = 0, ALUSrcB = 00 or 01 respectively, ALU decoded from cmd. Next state is ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = CondExReg AND NOT NoWrite. Next state is FETCH.
- ALU decode:
  - cmd 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR.
  - 1010 (CMP) → SUB, NoWrite = 1.
  - Any other cmd → ADD, NoWrite = 1 (a NOP with no register write).
- Flag update: Flags <= ALUFlags at the end of EXECR/EXECI when S = 1 and CondExReg = 1.
  - CMP always sets S-equivalent behaviour, i.e. it updates Flags even when S = 0.
  - Logical ops (AND/ORR) update only N and Z; C and V are kept.
- BRANCH: ALUSrcA = 0, ALUSrcB = 01, ResultSrc = 10, PCWrite = CondExReg. Next state is FETCH.
- VEXEC (vector):
  - Each cycle drives ALUSrcA = 0, ALUSrcB = Funct[5] ? 01 : 00, the decoded ALUControl, ResultSrc = 10, RegWrite = CondExReg AND NOT NoWrite, and LaneIdx = the current lane.
  - LaneIdx increments every cycle. When LaneIdx == LANES-1, the next state is FETCH and LaneIdx returns to 0.
  - Exactly LANES cycles are spent in VEXEC; no wrap beyond LANES-1.
  - Flags update only on the last lane, under the same S/CondExReg rule.
  - Total latency: LANES + 2 cycles.
- Latencies: ALU op 4 cycles, load 5, store 4, branch 3.
- CondExReg = 0 gates every architectural write (RegWrite, MemWrite, branch PCWrite, Flags) but never alters the state sequence. A false vector instruction still occupies LANES cycles.
- Asynchronous reset mid-instruction (including mid-VEXEC): immediate return to FETCH, Flags cleared, LaneIdx = 0; no partial write occurs after rst_n falls.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles → state FETCH, all write enables 0, LaneIdx = 0, Busy = 0. Release → IRWrite = 1 and PCWrite = 1 on the first clk.
- ADDS then conditional store: ADDS (Op 00, Funct 001001) with ALUFlags = 0100 → Flags = 0100 after EXECR and RegWrite = 1 in cycle 4. Next STR with Cond = 0000 (EQ) → MemWrite = 1 in MEMWR; with Cond = 0001 (NE) → MemWrite = 0, still 4 cycles.
- LDR (Op 01, Funct[0] = 1) → sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; ResultSrc = 01 and RegWrite = 1 in cycle 5.
- CMP with S = 0, ALUFlags = 1000 → Flags = 1000, RegWrite = 0 throughout. Following BLT (Cond 1011, Op 10) → PCWrite = 1 in BRANCH; BGE → PCWrite = 0.
- Vector ORR, LANES = 4 → 4 VEXEC cycles, LaneIdx 0, 1, 2, 3, RegWrite = 1 each, ALUControl = 0011; FETCH on cycle 7. Repeat with LANES = 8 → LaneIdx reaches 7.
- rst_n dropped asynchronously at LaneIdx = 2 → RegWrite falls in the same cycle, state FETCH, LaneIdx = 0, Flags = 0000.

Source files
------------

// File: rtl/multicycle_vector_controller.sv
// Multicycle control FSM for the Filter-GPU datapath.
// Adds NZCV flags, conditional execution and a vector-lane loop.
module multicycle_vector_controller #(
  parameter int LANES     = 4,
  parameter int LANE_W    = 2,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [LANE_W-1:0]    LaneIdx,
  output logic                 Busy
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, BRANCH, VEXEC
  } state_t;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
  localparam logic [LANE_W-1:0]    LAST    = LANE_W'(LANES-1);

  state_t              state_q, state_d;
  logic [3:0]          flags_q, flags_d;
  logic                condex_q, condex_d;
  logic [LANE_W-1:0]   lane_q, lane_d;

  logic                cond_ex;
  logic [ALUCTRL_W-1:0] alu_op;
  logic                no_write, logical, is_cmp;
  logic                flag_we;
  logic [3:0]          flags_nxt;
  logic                pc_we, ir_we, reg_we, mem_we;
  logic                unused_rd;

  assign unused_rd = ^Rd;

  always_comb begin
    cond_ex = 1'b0;
    unique case (Cond)
      4'h0: cond_ex = flags_q[2];
      4'h1: cond_ex = ~flags_q[2];
      4'h2: cond_ex = flags_q[1];
      4'h3: cond_ex = ~flags_q[1];
      4'h4: cond_ex = flags_q[3];
      4'h5: cond_ex = ~flags_q[3];
      4'h6: cond_ex = flags_q[0];
      4'h7: cond_ex = ~flags_q[0];
      4'h8: cond_ex = flags_q[1] & ~flags_q[2];
      4'h9: cond_ex = ~flags_q[1] | flags_q[2];
      4'ha: cond_ex = flags_q[3] == flags_q[0];
      4'hb: cond_ex = flags_q[3] != flags_q[0];
      4'hc: cond_ex = ~flags_q[2] &
                      (flags_q[3] == flags_q[0]);
      4'hd: cond_ex = flags_q[2] |
                      (flags_q[3] != flags_q[0]);
      4'he: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    alu_op   = ALU_ADD;
    no_write = 1'b0;
    logical  = 1'b0;
    is_cmp   = 1'b0;
    unique case (Funct[4:1])
      4'b0100: alu_op = ALU_ADD;
      4'b0010: alu_op = ALU_SUB;
      4'b0000: begin
        alu_op  = ALU_AND;
        logical = 1'b1;
      end
      4'b1100: begin
        alu_op  = ALU_ORR;
        logical = 1'b1;
      end
      4'b1010: begin
        alu_op   = ALU_SUB;
        no_write = 1'b1;
        is_cmp   = 1'b1;
      end
      default: no_write = 1'b1;
    endcase
  end

  // Logical ops leave carry and overflow untouched
  assign flag_we   = condex_q & (Funct[0] | is_cmp);
  assign flags_nxt = logical ?
                     {ALUFlags[3:2], flags_q[1:0]} :
                     ALUFlags;

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    condex_d   = condex_q;
    lane_d     = lane_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b1;
    ALUSrcB    = 2'b10;
    ResultSrc  = 2'b10;
    ALUControl = ALU_ADD;
    unique case (state_q)
      FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        condex_d = cond_ex;
        lane_d   = '0;
        unique case (1'b1)
          Op == 2'b01: state_d = MEMADR;
          Op == 2'b10: state_d = BRANCH;
          Op == 2'b11: state_d = VEXEC;
          default:     state_d = Funct[5] ? EXECI : EXECR;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_we    = condex_q;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc  = 1'b1;
        mem_we  = condex_q;
        state_d = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_op;
        if (flag_we) flags_d = flags_nxt;
        state_d    = ALUWB;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        reg_we    = condex_q & ~no_write;
        state_d   = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b01;
        pc_we   = condex_q;
        state_d = FETCH;
      end
      VEXEC: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = Funct[5] ? 2'b01 : 2'b00;
        ALUControl = alu_op;
        reg_we     = condex_q & ~no_write;
        if (lane_q == LAST) begin
          lane_d  = '0;
          state_d = FETCH;
          if (flag_we) flags_d = flags_nxt;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
      lane_q   <= '0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
      lane_q   <= lane_d;
    end
  end

  // Write enables drop the instant reset asserts
  assign PCWrite  = pc_we & rst_n;
  assign IRWrite  = ir_we & rst_n;
  assign RegWrite = reg_we & rst_n;
  assign MemWrite = mem_we & rst_n;
  assign LaneIdx  = (state_q == VEXEC) ? lane_q : '0;
  assign Busy     = state_q != FETCH;
  assign ImmSrc   = (Op == 2'b11) ? 2'b00 : Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};

endmodule
